// File: rtl/dna_mac_derive_if.sv
// Bus bundle between the DNA-derived MAC block and its neighbours.
//   dna / dna_valid : 57-bit DNA word and its validity level from the reader
//   regen           : one-cycle request to re-hash the latched DNA
//   mac / mac_valid : derived MAC address and its qualifier
//   busy            : hash in progress
//   cpu_addr/rdata  : byte-wide register read port (1-cycle latency)
// slave  = the derive block, master = whoever drives the inputs.
interface dna_mac_derive_if;
  logic [56:0] dna;
  logic        dna_valid;
  logic        regen;
  logic [47:0] mac;
  logic        mac_valid;
  logic        busy;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_rdata;

  modport slave (
    input  dna, dna_valid, regen, cpu_addr,
    output mac, mac_valid, busy, cpu_rdata
  );

  modport master (
    output dna, dna_valid, regen, cpu_addr,
    input  mac, mac_valid, busy, cpu_rdata
  );
endinterface

// File: rtl/dna_mac_derive.sv
// dna_mac_derive
// Latches the 57-bit FPGA DNA on the rising edge of dna_valid, runs it
// MSB-first through a bit-serial CRC-32 (poly 04C11DB7) and builds a locally
// administered unicast MAC: {MAC_OUI_BYTE, dna[7:0], crc ^ CRC_XOROUT}.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : dna_mac_derive_if.slave (dna/dna_valid/regen in, mac/mac_valid/
//           busy out, cpu_addr in / cpu_rdata out)
// Timing: start sampled at the end of cycle T -> HASH in T+1..T+57 (one DNA
// bit per cycle) -> mac/mac_valid visible from T+58.
module dna_mac_derive #(
  parameter logic [7:0]  MAC_OUI_BYTE = 8'h02,
  parameter logic [31:0] CRC_INIT     = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT   = 32'hFFFFFFFF
) (
  input  logic           clk,
  input  logic           reset,
  dna_mac_derive_if.slave bus
);

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [5:0]  LAST_BIT = 6'd56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } state_t;

  // Running hash: CRC register plus index of the DNA bit being consumed.
  typedef struct packed {
    logic [31:0] crc;
    logic [5:0]  cnt;
  } hash_ctx_t;

  localparam hash_ctx_t CTX_INIT = '{crc: CRC_INIT, cnt: 6'd0};

  state_t      state_q, state_d;
  hash_ctx_t   ctx_q;
  logic [56:0] dna_q;
  logic        dv_q;
  logic [47:0] mac_q;
  logic        mac_valid_q;
  logic [7:0]  rdata_q;

  // control decoded by the FSM
  logic start, fall;
  logic launch;    // (re)start a hash from CRC_INIT
  logic load_dna;  // capture a fresh DNA word with the launch
  logic abort;     // dna_valid went away: drop everything in flight
  logic finish;    // last DNA bit this cycle, register the MAC

  // datapath helpers
  logic [5:0]  bit_idx;
  logic        dna_bit;
  logic        fb;
  logic [31:0] crc_next;
  logic        busy;
  logic [7:0]  rd_mux;

  assign start = bus.dna_valid & ~dv_q;
  assign fall  = ~bus.dna_valid & dv_q;
  assign busy  = (state_q == HASH);

  // MSB first: cnt=0 consumes dna_q[56], cnt=56 consumes dna_q[0].
  assign bit_idx  = LAST_BIT - ctx_q.cnt;
  assign dna_bit  = dna_q[bit_idx];
  assign fb       = ctx_q.crc[31] ^ dna_bit;
  assign crc_next = {ctx_q.crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    load_dna = 1'b0;
    abort    = 1'b0;
    finish   = 1'b0;
    if (fall) begin
      // losing the DNA beats every other event, including completion
      state_d = IDLE;
      abort   = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // a rising edge wins over a coincident regen and reloads the DNA;
          // regen alone re-hashes what is already latched
          if (start) begin
            launch   = 1'b1;
            load_dna = 1'b1;
            state_d  = HASH;
          end else if (bus.regen && bus.dna_valid) begin
            launch  = 1'b1;
            state_d = HASH;
          end
        end
        HASH: begin
          // regen is deliberately not looked at here
          if (ctx_q.cnt == LAST_BIT) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Hash datapath and MAC register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q        <= 1'b0;
      dna_q       <= '0;
      ctx_q       <= CTX_INIT;
      mac_q       <= '0;
      mac_valid_q <= 1'b0;
    end else begin
      dv_q <= bus.dna_valid;
      if (abort) begin
        // partial CRC is thrown away; mac keeps its stale value unqualified
        ctx_q       <= CTX_INIT;
        mac_valid_q <= 1'b0;
      end else if (launch) begin
        ctx_q       <= CTX_INIT;
        mac_valid_q <= 1'b0;
        if (load_dna) dna_q <= bus.dna;
      end else if (state_q == HASH) begin
        ctx_q.crc <= crc_next;
        if (finish) begin
          // cnt parks at 56; it is re-seeded on the next launch
          mac_q       <= {MAC_OUI_BYTE, dna_q[7:0], crc_next ^ CRC_XOROUT};
          mac_valid_q <= 1'b1;
        end else begin
          ctx_q.cnt <= ctx_q.cnt + 6'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // CPU read port: plain decode, one register stage
  // ---------------------------------------------------------------------
  always_comb begin
    rd_mux = 8'h00;
    case (bus.cpu_addr)
      4'd0:    rd_mux = dna_q[7:0];
      4'd1:    rd_mux = dna_q[15:8];
      4'd2:    rd_mux = dna_q[23:16];
      4'd3:    rd_mux = dna_q[31:24];
      4'd4:    rd_mux = dna_q[39:32];
      4'd5:    rd_mux = dna_q[47:40];
      4'd6:    rd_mux = dna_q[55:48];
      4'd7:    rd_mux = {7'b0, dna_q[56]};
      4'd8:    rd_mux = mac_q[47:40];
      4'd9:    rd_mux = mac_q[39:32];
      4'd10:   rd_mux = mac_q[31:24];
      4'd11:   rd_mux = mac_q[23:16];
      4'd12:   rd_mux = mac_q[15:8];
      4'd13:   rd_mux = mac_q[7:0];
      4'd14:   rd_mux = {6'b0, busy, mac_valid_q};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= 8'h00;
    else        rdata_q <= rd_mux;
  end

  assign bus.mac       = mac_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.busy      = busy;
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dna_mac_derive.sv
// Bench for dna_mac_derive: directed scenarios plus a random phase, all
// checked every cycle against a timeline model (start edge + 57 cycles).
module tb_dna_mac_derive;

  localparam logic [56:0] DNA_A = 57'hAAAAAAAAAAAAAA;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dna_mac_derive_if ifc();

  dna_mac_derive dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_msb(input logic [71:0] d, input int n);
    logic [31:0] c;
    logic        f;
    c = 32'hFFFFFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      f = c[31] ^ d[i];
      c = {c[30:0], 1'b0} ^ (f ? 32'h04C11DB7 : 32'h0);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  function automatic logic [47:0] mac_of(input logic [56:0] d);
    return {8'h02, d[7:0], crc_msb({15'b0, d}, 57)};
  endfunction

  function automatic logic [7:0] rd_of(input logic [3:0] a, input logic [56:0] d,
                                       input logic [47:0] m, input logic act,
                                       input logic v);
    logic [63:0] dx;
    dx = {7'b0, d};
    if (a <= 4'd7)       return dx[8*a +: 8];
    else if (a <= 4'd13) return m[8*(13-a) +: 8];
    else if (a == 4'd14) return {6'b0, act, v};
    else                 return 8'h00;
  endfunction

  // m_k = edge index at which the current hash was launched
  logic        m_active = 1'b0, m_valid = 1'b0, m_pdv = 1'b0;
  logic [56:0] m_dna = '0;
  logic [47:0] m_mac = '0;
  logic [7:0]  m_rd  = '0;
  int          m_j = 0, m_k = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_valid <= 1'b0; m_pdv <= 1'b0;
      m_dna <= '0; m_mac <= '0; m_rd <= '0; m_j <= 0; m_k <= 0;
    end else begin
      m_j   <= m_j + 1;
      m_pdv <= ifc.dna_valid;
      m_rd  <= rd_of(ifc.cpu_addr, m_dna, m_mac, m_active, m_valid);
      if (m_pdv && !ifc.dna_valid) begin
        m_active <= 1'b0;
        m_valid  <= 1'b0;
      end else if (!m_active && ((ifc.dna_valid && !m_pdv) || (ifc.regen && ifc.dna_valid))) begin
        if (ifc.dna_valid && !m_pdv) m_dna <= ifc.dna;
        m_active <= 1'b1;
        m_valid  <= 1'b0;
        m_k      <= m_j;
      end else if (m_active && m_j == m_k + 57) begin
        m_active <= 1'b0;
        m_valid  <= 1'b1;
        m_mac    <= mac_of(m_dna);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp();
    if (reset) begin
      chk("busy",      ifc.busy,      m_active);
      chk("mac_valid", ifc.mac_valid, m_valid);
      chk("mac",       ifc.mac,       m_mac);
      chk("cpu_rdata", ifc.cpu_rdata, m_rd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp();
  endtask

  logic [47:0] gold;
  logic [71:0] chkstr;

  initial begin
    ifc.dna = '0; ifc.dna_valid = 1'b0; ifc.regen = 1'b0; ifc.cpu_addr = '0;

    // pin the CRC model: CRC-32/BZIP2 check value
    chkstr = "123456789";
    chk("crc_model_check", crc_msb(chkstr, 72), 32'hFC891918);
    gold = mac_of(DNA_A);

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int a = 0; a < 16; a++) begin
      ifc.cpu_addr = 4'(a);
      tick();
      chk("rst_read", ifc.cpu_rdata, 8'h00);
    end
    chk("rst_mac", ifc.mac, 48'h0);

    // normal derive, dna_valid raised in cycle T
    ifc.dna = DNA_A; ifc.dna_valid = 1'b1; ifc.cpu_addr = 4'd14;
    tick();                                   // T+1
    chk("busy_T1", ifc.busy, 1'b1);
    tick();                                   // T+2
    chk("status_hash", ifc.cpu_rdata, 8'h02);
    repeat (55) tick();                       // T+57
    chk("busy_T57", ifc.busy, 1'b1);
    chk("valid_T57", ifc.mac_valid, 1'b0);
    tick();                                   // T+58
    chk("busy_T58", ifc.busy, 1'b0);
    chk("valid_T58", ifc.mac_valid, 1'b1);
    chk("oui", ifc.mac[47:40], 8'h02);
    chk("dna_octet", ifc.mac[39:32], 8'hAA);
    chk("mac_normal", ifc.mac, gold);
    tick(); tick();
    chk("status_done", ifc.cpu_rdata, 8'h01);

    // register sweep
    for (int a = 8; a <= 13; a++) begin
      ifc.cpu_addr = 4'(a);
      tick();
      chk("sweep_octet", ifc.cpu_rdata, gold[8*(13-a) +: 8]);
    end
    ifc.cpu_addr = 4'd15; tick(); chk("addr15", ifc.cpu_rdata, 8'h00);

    // DNA isolation after DONE
    ifc.dna = 57'({$urandom, $urandom});
    repeat (3) tick();
    chk("iso_done_mac", ifc.mac, gold);
    ifc.cpu_addr = 4'd0; tick(); chk("iso_addr0", ifc.cpu_rdata, 8'hAA);
    ifc.cpu_addr = 4'd7; tick(); chk("iso_addr7", ifc.cpu_rdata, 8'h00);

    // regen from DONE, with a stray regen and dna change mid-hash
    ifc.regen = 1'b1; tick(); ifc.regen = 1'b0;   // R+1
    chk("regen_valid_drop", ifc.mac_valid, 1'b0);
    chk("regen_busy", ifc.busy, 1'b1);
    repeat (10) tick();
    ifc.dna = 57'({$urandom, $urandom});
    ifc.regen = 1'b1; tick(); ifc.regen = 1'b0;   // R+12
    repeat (45) tick();                           // R+57
    chk("regen_busy_R57", ifc.busy, 1'b1);
    tick();                                       // R+58
    chk("regen_valid_R58", ifc.mac_valid, 1'b1);
    chk("regen_mac", ifc.mac, gold);
    ifc.cpu_addr = 4'd0; tick(); tick();
    chk("iso_hash_addr0", ifc.cpu_rdata, 8'hAA);

    // abort at T+20, then full re-run
    ifc.dna_valid = 1'b0; tick();
    chk("fall_valid", ifc.mac_valid, 1'b0);
    ifc.dna = DNA_A; ifc.dna_valid = 1'b1;
    repeat (20) tick();                           // T+20
    ifc.dna_valid = 1'b0;
    tick();                                       // T+21
    chk("abort_busy", ifc.busy, 1'b0);
    chk("abort_valid", ifc.mac_valid, 1'b0);
    repeat (3) tick();
    chk("abort_valid_hold", ifc.mac_valid, 1'b0);
    ifc.dna_valid = 1'b1;
    repeat (57) tick();
    chk("rerun_busy", ifc.busy, 1'b1);
    tick();
    chk("rerun_valid", ifc.mac_valid, 1'b1);
    chk("rerun_mac", ifc.mac, gold);

    // asynchronous reset in the middle of a hash
    ifc.dna_valid = 1'b0; tick();
    ifc.dna_valid = 1'b1; repeat (10) tick();
    #3 reset = 1'b0; ifc.dna_valid = 1'b0;
    #1;
    chk("arst_busy", ifc.busy, 1'b0);
    chk("arst_valid", ifc.mac_valid, 1'b0);
    chk("arst_mac", ifc.mac, 48'h0);
    chk("arst_rdata", ifc.cpu_rdata, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ifc.cpu_addr = 4'(a);
      tick();
      chk("arst_read", ifc.cpu_rdata, 8'h00);
    end

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) ifc.dna_valid = ~ifc.dna_valid;
      ifc.regen    = ($urandom_range(0, 19) == 0);
      ifc.dna      = 57'({$urandom, $urandom});
      ifc.cpu_addr = 4'($urandom_range(0, 15));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dna_mac_derive.md
Name: dna_mac_derive

Overview:
- Downstream consumer of the 57-bit FPGA DNA word produced by the DNA-port reader.
- Latches the DNA once the reader signals it is valid, then hashes it bit-serially with CRC-32.
- Produces a stable, locally administered unicast MAC address for the Ethernet controller.
- Exposes the DNA, the MAC and a status byte through a byte-wide, registered CPU read port.

Parameters:
- MAC_OUI_BYTE, 8'h02, first MAC octet. Bit1 = locally administered, bit0 = unicast.
- CRC_INIT, 32'hFFFFFFFF, CRC register seed.
- CRC_XOROUT, 32'hFFFFFFFF, value XORed into the CRC when the result is registered.

Ports:
- clk  in  1  system clock; every register in the block is on this clock.
- reset  in  1  asynchronous, active-low reset.
- dna  in  57  DNA word from the upstream reader. Only sampled at capture.
- dna_valid  in  1  level from the upstream reader; high while dna is complete and stable.
- regen  in  1  single-cycle pulse; re-runs the hash on the latched DNA.
- mac  out  48  derived MAC address; mac[47:40] is the first octet on the wire.
- mac_valid  out  1  high while mac holds a completed result.
- busy  out  1  high in the HASH state.
- cpu_addr  in  4  read-register select.
- cpu_rdata  out  8  registered read data.

Behaviour:
- Reset (reset=0, asynchronous), all of the following are cleared:
  - state=IDLE; dna_q=0; crc=CRC_INIT; cnt=0; dv_q=0.
  - mac=0, mac_valid=0, busy=0, cpu_rdata=0.
- dv_q is a one-cycle delayed copy of dna_valid. start = dna_valid & ~dv_q (rising edge).
- State IDLE:
  - start at cycle T: dna_q<=dna, crc<=CRC_INIT, cnt<=0, mac_valid<=0, go to HASH.
  - regen while dna_valid=1: same as start, but dna_q is not reloaded.
  - regen while dna_valid=0: ignored.
- State HASH, one bit per cycle, MSB first:
  - bit b = dna_q[56-cnt].
  - fb = crc[31]^b; crc <= {crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
  - cnt increments each cycle.
  - On the cycle with cnt==56: mac <= {MAC_OUI_BYTE, dna_q[7:0], (crc_next ^ CRC_XOROUT)}, mac_valid<=1, go to DONE.
  - Latency: HASH occupies cycles T+1..T+57; mac/mac_valid are visible from T+58.
  - busy=1 exactly for those 57 cycles.
- State DONE:
  - mac and mac_valid hold.
  - regen (with dna_valid=1) or a new start restarts as in IDLE; mac_valid drops the following cycle.
- dna_valid falling, in any state:
  - Next state IDLE, mac_valid<=0, busy<=0.
  - mac keeps its old value but is not qualified.
  - An abort mid-HASH discards the partial CRC.
- Simultaneous events:
  - start and regen in the same cycle act as start.
  - regen during HASH is ignored.
  - The dna_valid fall has priority over everything else.
- cnt is 6 bits and never exceeds 56; it does not wrap.
- CPU read port: cpu_rdata is registered, 1-cycle latency, and always readable regardless of state.
  - Addresses 0..6: dna_q byte n = dna_q[8n+7:8n].
  - Address 7: {7'b0, dna_q[56]}.
  - Addresses 8..13: MAC octets, addr 8 = mac[47:40] through addr 13 = mac[7:0].
  - Address 14: {6'b0, busy, mac_valid}.
  - Address 15: 8'h00.

Test Plan:
- Reset check: hold reset=0 mid-operation, release -> mac=0, mac_valid=0, busy=0, cpu_rdata=0.
  - Reads of addresses 0..15 all return 8'h00 with status 8'h00.
- Normal derive: dna=57'h0AAAAAAAAAAAAAA, raise dna_valid at cycle T.
  - busy high T+1..T+57; mac_valid=1 from T+58.
  - mac[47:40]=8'h02, mac[39:32]=8'hAA; mac[31:0] equals a bench CRC-32 model (MSB-first, init/xorout FFFFFFFF).
- Abort: drop dna_valid at T+20 -> IDLE next cycle, busy=0, mac_valid stays 0.
  - Re-raising dna_valid gives the full 58-cycle result identical to the normal-derive case.
- Regen from DONE: pulse regen -> mac_valid=0 the next cycle, 57 cycles busy, mac_valid=1 again with an identical mac.
  - Regen while in HASH has no effect on the completion cycle.
- DNA isolation: change the dna input during HASH and after DONE -> mac and the readback are unchanged.
  - dna_q readback: addr 7 = 8'h00, addr 0 = 8'hAA.
- Register sweep: after done, read addresses 8..13 -> octets match mac with 1-cycle latency.
  - Address 14 reads 8'h01 in DONE and 8'h02 during HASH; address 15 reads 8'h00.
